fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register of the MIPS32 pipelined core. Owns the fetch PC, issues in-order word reads to instruction memory over a valid/ready request channel, and buffers returned instructions with their PC+1. Presents one instruction per cycle to IF/ID, stalling on `hold`. A control-flow redirect (branch or jump) flushes buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
- `DEPTH`, 4: queue entries and the maximum outstanding requests; power of two, 2–16.
- `ADDR_W`, 8: instruction word-address width.
- `DATA_W`, 32: instruction width.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `redirect`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  new fetch word address.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_addr`  out  ADDR_W  read word address.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_rsp_valid`  in  1  read data valid; responses return in request order, latency ≥1 cycle.
- `imem_rsp_data`  in  DATA_W  instruction word.
- `out_valid`  out  1  head entry holds an instruction.
- `out_ready`  in  1  IF/ID accepts the head; driven as `~hold`.
- `out_ir`  out  DATA_W  head instruction.
- `out_pc_p1`  out  ADDR_W  head PC + 1, mod 2^ADDR_W.
- `occupancy`  out  clog2(DEPTH)+1  allocated entries (filled plus in-flight).

## Operation
- Circular buffer of DEPTH entries `{pc, ir}` with three pointers of clog2(DEPTH)+1 bits each: `alloc`, `fill`, and `rd`. Also holds the registers `fetch_pc` and `drop_cnt`.
- Issue: `imem_req_valid = (alloc - rd) + drop_cnt < DEPTH && !redirect`. On valid&ready: write `pc[alloc] = fetch_pc`, then increment `alloc` and `fetch_pc`. `fetch_pc` wraps at 2^ADDR_W.
- Response: if `drop_cnt != 0`, decrement `drop_cnt` and discard the data. Otherwise write `ir[fill] = imem_rsp_data` and increment `fill`. A response with no outstanding request is ignored.
- Output: `out_valid = (rd != fill)`. The head is `ir[rd]` and `pc[rd]+1`. On valid&ready, `rd` increments.
- Redirect, which has priority over everything:
  - Set `alloc = fill = rd = 0` and `fetch_pc = redirect_pc`.
  - Set `drop_cnt_next = drop_cnt + (alloc - fill) - rsp_valid`. A same-cycle response is counted as dropped.
  - A same-cycle dequeue is void; the head is flushed.
  - No request is issued in the redirect cycle.
- Total outstanding requests (`alloc - fill + drop_cnt`) never exceed DEPTH, so `drop_cnt` fits in clog2(DEPTH)+1 bits.
- Modes: FETCH when `drop_cnt == 0`, DISCARD otherwise. New requests are allowed in DISCARD, subject to the outstanding limit.

## Timing
- Reset values: `fetch_pc = 0`, all pointers 0, `drop_cnt = 0`, `imem_req_valid = 1` (request to address 0 is combinational from registers), `out_valid = 0`, `out_ir = 0`, `out_pc_p1 = 1`, `occupancy = 0`.
- `imem_req_*` and `out_*` are combinational from registers only; there is no input-to-output combinational path except `redirect` → `imem_req_valid`.
- Response in cycle t gives `out_valid` in cycle t+1 (no bypass).
- Redirect in cycle t gives a request at `redirect_pc` in cycle t+1, if `drop_cnt + 0 < DEPTH`.
- Full (occupancy = DEPTH): issue stops. Responses still fill. A dequeue frees the slot, and issue resumes the next cycle.
- `hold` held high: the head is stable and responses continue until all allocated entries are filled.
- Reset asserted mid-operation clears all state immediately. Responses arriving after reset release are ignored as having no outstanding request.

## Structure
- Shared package `fetch_pkg`: `ADDR_W`, `DATA_W`, and the `fq_entry_t {pc, ir}` typedef.
- Sub-module `fq_storage`: a DEPTH-entry register array with separate pc-write, ir-write, and read ports. Pointers, counters, and the mode logic stay in `fetch_queue`.

## Test plan
- Reset release, ready=1, 1-cycle memory returning `0x1000_0000+addr`: out_valid from cycle 2; out_ir sequence `0x1000_0000`, `0x1000_0001`, …; out_pc_p1 sequence 1, 2, 3, ….
- `hold` (out_ready=0) from reset with 3-cycle latency: requests to addresses 0–3 only; occupancy reaches 4; imem_req_valid=0 until the first dequeue.
- Redirect to 0x40 with 2 requests in flight: the next 2 responses are discarded, drop_cnt goes 2→0, the first output is the instruction at 0x40 with out_pc_p1=0x41.
- Redirect in the same cycle as a response and a dequeue: the response is dropped, no instruction for the old path is output, and the request at redirect_pc is issued the next cycle.
- Wrap: redirect to 0xFE, then run: addresses issued 0xFE, 0xFF, 0x00; out_pc_p1 values 0xFF, 0x00, 0x01.
- Reset asserted while 3 requests are outstanding: outputs go to reset values asynchronously, stray responses after release are ignored, and fetch restarts at 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths and entry/mode types for the instruction prefetch queue.
package fetch_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
  } fq_entry_t;

  typedef enum logic {FETCH = 1'b0, DISCARD = 1'b1} fq_mode_t;
endpackage

// File: rtl/fq_storage.sv
// DEPTH-entry {pc, ir} register array: pc written at issue, ir at response, read at head.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_we,
  input  logic [IW-1:0]     pc_waddr,
  input  logic [ADDR_W-1:0] pc_wdata,
  input  logic              ir_we,
  input  logic [IW-1:0]     ir_waddr,
  input  logic [DATA_W-1:0] ir_wdata,
  input  logic [IW-1:0]     raddr,
  output fq_entry_t         rdata
);
  fq_entry_t mem [DEPTH];

  // Entries clear on reset so the idle head reads ir=0, pc=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pc_we) mem[pc_waddr].pc <= pc_wdata;
      if (ir_we) mem[ir_waddr].ir <= ir_wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns fetch PC, issues in-order reads, buffers returns,
// and flushes on redirect while counting in-flight responses to discard.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ir,
  output logic [ADDR_W-1:0] out_pc_p1,
  output logic [PW-1:0]     occupancy
);
  localparam int IW = PW - 1;

  logic [PW-1:0]     alloc, fill, rd, drop_cnt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0]     in_flight;
  logic [PW:0]       committed;
  fq_mode_t          mode;
  logic              issue, rsp_drop, rsp_fill, deq;
  fq_entry_t         head;

  assign in_flight = alloc - fill;
  assign occupancy = alloc - rd;
  // Stale requests still owed by memory count against the outstanding limit.
  assign committed = {1'b0, occupancy} + {1'b0, drop_cnt};
  assign mode      = (drop_cnt != '0) ? DISCARD : FETCH;

  assign imem_req_valid = (committed < (PW+1)'(DEPTH)) && !redirect;
  assign imem_req_addr  = fetch_pc;
  assign issue          = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (mode == DISCARD);
  assign rsp_fill       = imem_rsp_valid && (mode == FETCH) && (in_flight != '0);

  assign out_valid = (rd != fill);
  assign deq       = out_valid && out_ready;
  assign out_ir    = head.ir;
  assign out_pc_p1 = head.pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc    <= '0;
      fill     <= '0;
      rd       <= '0;
      drop_cnt <= '0;
      fetch_pc <= '0;
    end else if (redirect) begin
      alloc    <= '0;
      fill     <= '0;
      rd       <= '0;
      fetch_pc <= redirect_pc;
      // Everything in flight becomes stale; a response arriving now is already accounted.
      drop_cnt <= drop_cnt + in_flight - PW'(rsp_drop || rsp_fill);
    end else begin
      if (issue) begin
        alloc    <= alloc + PW'(1);
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      if (rsp_drop) drop_cnt <= drop_cnt - PW'(1);
      if (rsp_fill) fill <= fill + PW'(1);
      if (deq)      rd   <= rd + PW'(1);
    end
  end

  fq_storage #(.DEPTH(DEPTH), .IW(IW)) u_storage (
    .clk      (clk),
    .reset    (reset),
    .pc_we    (issue),
    .pc_waddr (alloc[IW-1:0]),
    .pc_wdata (fetch_pc),
    .ir_we    (rsp_fill && !redirect),
    .ir_waddr (fill[IW-1:0]),
    .ir_wdata (imem_rsp_data),
    .raddr    (rd[IW-1:0]),
    .rdata    (head)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue with an in-order fixed-latency memory model.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        imem_req_valid;
  logic [7:0]  imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [7:0]  out_pc_p1;
  logic [2:0]  occupancy;

  fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_pc_p1(out_pc_p1), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hold;
    logic        redir;
    logic [7:0]  rpc;
    logic        rv;
    logic [7:0]  ra;
    logic        ov;
    logic [31:0] ir;
    logic [7:0]  pc1;
    logic [2:0]  occ;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] addr;
  } pend_t;

  vec_t  tv[$];
  pend_t pend[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc;
  int    lat;
  int    s[8];

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  function automatic void add(input logic h, input logic r, input logic [7:0] rpc,
                              input logic rv, input logic [7:0] ra, input logic ov,
                              input logic [31:0] ir, input logic [7:0] pc1, input logic [2:0] occ);
    vec_t v;
    v.hold = h; v.redir = r; v.rpc = rpc; v.rv = rv; v.ra = ra;
    v.ov = ov; v.ir = ir; v.pc1 = pc1; v.occ = occ;
    tv.push_back(v);
  endfunction

  // One clock: memory accepts/returns, then next-cycle response is presented.
  task automatic tick();
    logic       fire;
    logic [7:0] a;
    logic       rf;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    rf   = imem_rsp_valid;
    @(posedge clk);
    if (rf) void'(pend.pop_front());
    if (fire) pend.push_back('{due: cyc + lat, addr: a});
    cyc++;
    @(negedge clk);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1000_0000 + {24'h0, pend[0].addr};
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic check_reset_vals(input int row);
    chk("rst_req_valid", row, {31'h0, imem_req_valid}, 32'd1);
    chk("rst_req_addr",  row, {24'h0, imem_req_addr},  32'd0);
    chk("rst_out_valid", row, {31'h0, out_valid},      32'd0);
    chk("rst_out_ir",    row, out_ir,                  32'd0);
    chk("rst_pc_p1",     row, {24'h0, out_pc_p1},      32'd1);
    chk("rst_occ",       row, {29'h0, occupancy},      32'd0);
  endtask

  task automatic do_reset(input int l);
    reset = 1'b0; imem_req_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    out_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    pend.delete(); cyc = 0; lat = l;
    @(negedge clk);
    #1 check_reset_vals(-1);
    @(negedge clk);
    reset = 1'b1; imem_req_ready = 1'b1;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      out_ready   = ~tv[i].hold;
      redirect    = tv[i].redir;
      redirect_pc = tv[i].rpc;
      #1;
      chk("req_valid", i, {31'h0, imem_req_valid}, {31'h0, tv[i].rv});
      if (tv[i].rv) chk("req_addr", i, {24'h0, imem_req_addr}, {24'h0, tv[i].ra});
      chk("out_valid", i, {31'h0, out_valid}, {31'h0, tv[i].ov});
      if (tv[i].ov) begin
        chk("out_ir", i, out_ir, tv[i].ir);
        chk("out_pc_p1", i, {24'h0, out_pc_p1}, {24'h0, tv[i].pc1});
      end
      chk("occupancy", i, {29'h0, occupancy}, {29'h0, tv[i].occ});
      tick();
    end
    redirect = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    // A: streaming, latency 1, no hold
    s[0] = tv.size();
    add(0,0,0, 1,8'h00, 0,0,0, 0);
    add(0,0,0, 1,8'h01, 0,0,0, 1);
    add(0,0,0, 1,8'h02, 1,32'h1000_0000,8'h01, 2);
    add(0,0,0, 1,8'h03, 1,32'h1000_0001,8'h02, 2);
    add(0,0,0, 1,8'h04, 1,32'h1000_0002,8'h03, 2);
    add(0,0,0, 1,8'h05, 1,32'h1000_0003,8'h04, 2);
    // B: hold from reset, latency 3; fills to DEPTH, issue resumes after one dequeue
    s[1] = tv.size();
    add(1,0,0, 1,8'h00, 0,0,0, 0);
    add(1,0,0, 1,8'h01, 0,0,0, 1);
    add(1,0,0, 1,8'h02, 0,0,0, 2);
    add(1,0,0, 1,8'h03, 0,0,0, 3);
    add(1,0,0, 0,0,     1,32'h1000_0000,8'h01, 4);
    add(1,0,0, 0,0,     1,32'h1000_0000,8'h01, 4);
    add(1,0,0, 0,0,     1,32'h1000_0000,8'h01, 4);
    add(1,0,0, 0,0,     1,32'h1000_0000,8'h01, 4);
    add(0,0,0, 0,0,     1,32'h1000_0000,8'h01, 4);
    add(1,0,0, 1,8'h04, 1,32'h1000_0001,8'h02, 3);
    // C: redirect to 0x40 with 2 in flight, latency 3
    s[2] = tv.size();
    add(0,0,0,     1,8'h00, 0,0,0, 0);
    add(0,0,0,     1,8'h01, 0,0,0, 1);
    add(0,1,8'h40, 0,0,     0,0,0, 2);
    add(0,0,0,     1,8'h40, 0,0,0, 0);
    add(0,0,0,     1,8'h41, 0,0,0, 1);
    add(0,0,0,     1,8'h42, 0,0,0, 2);
    add(0,0,0,     1,8'h43, 0,0,0, 3);
    add(0,0,0,     0,0,     1,32'h1000_0040,8'h41, 4);
    add(0,0,0,     1,8'h44, 1,32'h1000_0041,8'h42, 3);
    // D: redirect coincident with response and dequeue, latency 1
    s[3] = tv.size();
    add(0,0,0,     1,8'h00, 0,0,0, 0);
    add(0,0,0,     1,8'h01, 0,0,0, 1);
    add(0,0,0,     1,8'h02, 1,32'h1000_0000,8'h01, 2);
    add(0,1,8'h80, 0,0,     1,32'h1000_0001,8'h02, 2);
    add(0,0,0,     1,8'h80, 0,0,0, 0);
    add(0,0,0,     1,8'h81, 0,0,0, 1);
    add(0,0,0,     1,8'h82, 1,32'h1000_0080,8'h81, 2);
    // E: address wrap after redirect to 0xFE, latency 1
    s[4] = tv.size();
    add(0,1,8'hFE, 0,0,     0,0,0, 0);
    add(0,0,0,     1,8'hFE, 0,0,0, 0);
    add(0,0,0,     1,8'hFF, 0,0,0, 1);
    add(0,0,0,     1,8'h00, 1,32'h1000_00FE,8'hFF, 2);
    add(0,0,0,     1,8'h01, 1,32'h1000_00FF,8'h00, 2);
    add(0,0,0,     1,8'h02, 1,32'h1000_0000,8'h01, 2);
    // F: three outstanding, then async reset; strays after release ignored
    s[5] = tv.size();
    add(1,0,0, 1,8'h00, 0,0,0, 0);
    add(1,0,0, 1,8'h01, 0,0,0, 1);
    add(1,0,0, 1,8'h02, 0,0,0, 2);
    s[6] = tv.size();
    add(1,0,0, 1,8'h00, 0,0,0, 0);
    add(1,0,0, 1,8'h01, 0,0,0, 1);
    add(1,0,0, 1,8'h02, 0,0,0, 2);
    add(1,0,0, 1,8'h03, 0,0,0, 3);
    add(1,0,0, 0,0,     0,0,0, 4);
    add(1,0,0, 0,0,     1,32'h1000_0000,8'h01, 4);
    s[7] = tv.size();

    do_reset(1); run(s[0], s[1]-1);
    do_reset(3); run(s[1], s[2]-1);
    do_reset(3); run(s[2], s[3]-1);
    do_reset(1); run(s[3], s[4]-1);
    do_reset(1); run(s[4], s[5]-1);

    do_reset(4); run(s[5], s[6]-1);
    #1 chk("pre_rst_occ", 100, {29'h0, occupancy}, 32'd3);
    reset = 1'b0; imem_req_ready = 1'b0;
    #1 check_reset_vals(101);
    repeat (3) tick();
    reset = 1'b1; imem_req_ready = 1'b1;
    run(s[6], s[7]-1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
